// File: rtl/trg_lat_stats.sv
// rtl/trg_lat_stats.sv - per-window latency statistics (count, min, max, sum)
// Closing a window copies the statistics to held outputs and restarts the accumulators.
module trg_lat_stats #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 24
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             SMPL_VLD,
  input  logic [7:0]       TIME,
  input  logic             SNAP,
  output logic             READY,
  output logic             SNAP_VLD,
  output logic [CNT_W-1:0] NSMPL,
  output logic [7:0]       MIN,
  output logic [7:0]       MAX,
  output logic [SUM_W-1:0] SUM,
  output logic             EMPTY,
  output logic             OVFL
);

  typedef enum logic {ACCUM, COPY} state_t;

  state_t           state, state_nxt;
  logic             s1_vld;
  logic [7:0]       s1_time;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SUM_W-1:0] sum, sum_nxt;
  logic [SUM_W:0]   sum_add;
  logic [7:0]       min_q, min_nxt, max_q, max_nxt;
  logic             ovfl, ovfl_nxt;
  logic             empty_nxt;

  logic [CNT_W-1:0] nsmpl_q;
  logic [7:0]       min_o, max_o;
  logic [SUM_W-1:0] sum_o;
  logic             empty_o, ovfl_o;

  // Accumulators combined with the stage-1 sample; used both to accumulate and to close a window.
  always_comb begin
    cnt_nxt  = cnt;
    sum_nxt  = sum;
    min_nxt  = min_q;
    max_nxt  = max_q;
    ovfl_nxt = ovfl;
    sum_add  = {1'b0, sum} + {{(SUM_W-7){1'b0}}, s1_time};
    if (s1_vld) begin
      if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
      if (cnt_nxt == '1) ovfl_nxt = 1'b1;
      if (sum_add[SUM_W]) begin
        sum_nxt  = '1;
        ovfl_nxt = 1'b1;
      end else begin
        sum_nxt = sum_add[SUM_W-1:0];
      end
      if (s1_time < min_q) min_nxt = s1_time;
      if (s1_time > max_q) max_nxt = s1_time;
    end
    empty_nxt = (cnt_nxt == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (SNAP) state_nxt = COPY;
      COPY:    state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // During COPY the ports show the closing window directly so data and SNAP_VLD coincide.
  always_comb begin
    READY    = (state == ACCUM);
    SNAP_VLD = (state == COPY);
    NSMPL    = nsmpl_q;
    MIN      = min_o;
    MAX      = max_o;
    SUM      = sum_o;
    EMPTY    = empty_o;
    OVFL     = ovfl_o;
    if (state == COPY) begin
      NSMPL = cnt_nxt;
      MIN   = empty_nxt ? 8'h00 : min_nxt;
      MAX   = empty_nxt ? 8'h00 : max_nxt;
      SUM   = sum_nxt;
      EMPTY = empty_nxt;
      OVFL  = ovfl_nxt;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= ACCUM;
      s1_vld  <= 1'b0;
      s1_time <= 8'h00;
      cnt     <= '0;
      sum     <= '0;
      min_q   <= 8'hFF;
      max_q   <= 8'h00;
      ovfl    <= 1'b0;
      nsmpl_q <= '0;
      min_o   <= 8'h00;
      max_o   <= 8'h00;
      sum_o   <= '0;
      empty_o <= 1'b0;
      ovfl_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      s1_vld  <= SMPL_VLD;
      s1_time <= TIME;
      if (state == COPY) begin
        nsmpl_q <= cnt_nxt;
        min_o   <= empty_nxt ? 8'h00 : min_nxt;
        max_o   <= empty_nxt ? 8'h00 : max_nxt;
        sum_o   <= sum_nxt;
        empty_o <= empty_nxt;
        ovfl_o  <= ovfl_nxt;
        cnt     <= '0;
        sum     <= '0;
        min_q   <= 8'hFF;
        max_q   <= 8'h00;
        ovfl    <= 1'b0;
      end else begin
        cnt   <= cnt_nxt;
        sum   <= sum_nxt;
        min_q <= min_nxt;
        max_q <= max_nxt;
        ovfl  <= ovfl_nxt;
      end
    end
  end

endmodule

// File: tb/tb_trg_lat_stats.sv
// tb/tb_trg_lat_stats.sv - scoreboard bench for trg_lat_stats
// Directed stimulus pushes expected snapshots; a negedge monitor pops and compares on SNAP_VLD.
module tb_trg_lat_stats;

  typedef struct {
    logic [15:0] n;
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [23:0] s;
    logic        e;
    logic        o;
  } exp_t;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  always #5 CLK = ~CLK;

  logic        smpl_vld0 = 1'b0, snap0 = 1'b0;
  logic [7:0]  time0 = 8'h00;
  logic        ready0, snap_vld0, empty0, ovfl0;
  logic [15:0] nsmpl0;
  logic [7:0]  min0, max0;
  logic [23:0] sum0;

  logic        smpl_vld1 = 1'b0, snap1 = 1'b0;
  logic [7:0]  time1 = 8'h00;
  logic        ready1, snap_vld1, empty1, ovfl1;
  logic [3:0]  nsmpl1;
  logic [7:0]  min1, max1;
  logic [7:0]  sum1;

  trg_lat_stats u0 (
    .CLK(CLK), .CLR(CLR), .SMPL_VLD(smpl_vld0), .TIME(time0), .SNAP(snap0),
    .READY(ready0), .SNAP_VLD(snap_vld0), .NSMPL(nsmpl0), .MIN(min0), .MAX(max0),
    .SUM(sum0), .EMPTY(empty0), .OVFL(ovfl0)
  );

  trg_lat_stats #(.CNT_W(4), .SUM_W(8)) u1 (
    .CLK(CLK), .CLR(CLR), .SMPL_VLD(smpl_vld1), .TIME(time1), .SNAP(snap1),
    .READY(ready1), .SNAP_VLD(snap_vld1), .NSMPL(nsmpl1), .MIN(min1), .MAX(max1),
    .SUM(sum1), .EMPTY(empty1), .OVFL(ovfl1)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   pulses0[$];
  exp_t e0, e1;

  always @(posedge CLK) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (snap_vld0 === 1'b1) begin
      pulses0.push_back(cyc);
      chk("ready_in_copy0", 32'(ready0), 32'd0);
      if (q0.size() == 0) chk("unexpected_snap0", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("nsmpl0", 32'(nsmpl0), 32'(e0.n));
        chk("min0", 32'(min0), 32'(e0.mn));
        chk("max0", 32'(max0), 32'(e0.mx));
        chk("sum0", 32'(sum0), 32'(e0.s));
        chk("empty0", 32'(empty0), 32'(e0.e));
        chk("ovfl0", 32'(ovfl0), 32'(e0.o));
      end
    end
    if (snap_vld1 === 1'b1) begin
      chk("ready_in_copy1", 32'(ready1), 32'd0);
      if (q1.size() == 0) chk("unexpected_snap1", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("nsmpl1", 32'(nsmpl1), 32'(e1.n));
        chk("min1", 32'(min1), 32'(e1.mn));
        chk("max1", 32'(max1), 32'(e1.mx));
        chk("sum1", 32'(sum1), 32'(e1.s));
        chk("empty1", 32'(empty1), 32'(e1.e));
        chk("ovfl1", 32'(ovfl1), 32'(e1.o));
      end
    end
  end

  task automatic cyc0(input logic v, input logic [7:0] t, input logic s);
    smpl_vld0 = v; time0 = t; snap0 = s;
    @(posedge CLK); #1;
    smpl_vld0 = 1'b0; snap0 = 1'b0;
  endtask

  task automatic cyc1(input logic v, input logic [7:0] t, input logic s);
    smpl_vld1 = v; time1 = t; snap1 = s;
    @(posedge CLK); #1;
    smpl_vld1 = 1'b0; snap1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic exp0(input logic [15:0] n, input logic [7:0] mn, input logic [7:0] mx,
                      input logic [23:0] s, input logic e, input logic o);
    exp_t x;
    x.n = n; x.mn = mn; x.mx = mx; x.s = s; x.e = e; x.o = o;
    q0.push_back(x);
  endtask

  task automatic exp1(input logic [15:0] n, input logic [7:0] mn, input logic [7:0] mx,
                      input logic [23:0] s, input logic e, input logic o);
    exp_t x;
    x.n = n; x.mn = mn; x.mx = mx; x.s = s; x.e = e; x.o = o;
    q1.push_back(x);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready0), 32'd1);
    chk({tag, "_snap_vld"}, 32'(snap_vld0), 32'd0);
    chk({tag, "_nsmpl"}, 32'(nsmpl0), 32'd0);
    chk({tag, "_min"}, 32'(min0), 32'd0);
    chk({tag, "_max"}, 32'(max0), 32'd0);
    chk({tag, "_sum"}, 32'(sum0), 32'd0);
    chk({tag, "_empty"}, 32'(empty0), 32'd0);
    chk({tag, "_ovfl"}, 32'(ovfl0), 32'd0);
  endtask

  initial begin
    int n0;
    int budget;
    #12;
    chk_zero_outputs("reset");
    @(posedge CLK); #1;
    CLR = 1'b0;
    idle(2);

    // empty window straight after reset
    exp0(16'd0, 8'h00, 8'h00, 24'h0, 1'b1, 1'b0);
    cyc0(1'b0, 8'h00, 1'b1);
    idle(2);

    // four samples, then an empty window
    cyc0(1'b1, 8'h10, 1'b0);
    cyc0(1'b1, 8'h05, 1'b0);
    cyc0(1'b1, 8'h3C, 1'b0);
    cyc0(1'b1, 8'h05, 1'b0);
    exp0(16'd4, 8'h05, 8'h3C, 24'h56, 1'b0, 1'b0);
    cyc0(1'b0, 8'h00, 1'b1);
    idle(2);
    exp0(16'd0, 8'h00, 8'h00, 24'h0, 1'b1, 1'b0);
    cyc0(1'b0, 8'h00, 1'b1);
    idle(2);

    // window boundary: sample with SNAP closes window, sample during COPY opens next
    cyc0(1'b1, 8'h20, 1'b0);
    exp0(16'd2, 8'h20, 8'h30, 24'h50, 1'b0, 1'b0);
    cyc0(1'b1, 8'h30, 1'b1);
    cyc0(1'b1, 8'h40, 1'b0);
    idle(2);
    exp0(16'd1, 8'h40, 8'h40, 24'h40, 1'b0, 1'b0);
    cyc0(1'b0, 8'h00, 1'b1);
    idle(2);

    // SNAP held four cycles
    n0 = pulses0.size();
    exp0(16'd0, 8'h00, 8'h00, 24'h0, 1'b1, 1'b0);
    exp0(16'd0, 8'h00, 8'h00, 24'h0, 1'b1, 1'b0);
    repeat (4) cyc0(1'b0, 8'h00, 1'b1);
    idle(3);
    chk("held_snap_pulses", 32'(pulses0.size() - n0), 32'd2);
    if (pulses0.size() >= n0 + 2)
      chk("held_snap_spacing", 32'(pulses0[n0+1] - pulses0[n0]), 32'd2);

    // saturation on the narrow instance
    repeat (20) cyc1(1'b1, 8'hFF, 1'b0);
    exp1(16'hF, 8'hFF, 8'hFF, 24'hFF, 1'b0, 1'b1);
    cyc1(1'b0, 8'h00, 1'b1);
    idle(2);
    cyc1(1'b1, 8'h01, 1'b0);
    exp1(16'h1, 8'h01, 8'h01, 24'h01, 1'b0, 1'b0);
    cyc1(1'b0, 8'h00, 1'b1);
    idle(2);

    // asynchronous clear mid-window
    cyc0(1'b1, 8'h11, 1'b0);
    cyc0(1'b1, 8'h22, 1'b0);
    exp0(16'd2, 8'h11, 8'h22, 24'h33, 1'b0, 1'b0);
    cyc0(1'b0, 8'h00, 1'b1);
    idle(2);
    chk("pre_clr_nsmpl", 32'(nsmpl0), 32'd2);
    cyc0(1'b1, 8'h01, 1'b0);
    cyc0(1'b1, 8'h02, 1'b0);
    smpl_vld0 = 1'b1; time0 = 8'h03;
    #2;
    CLR = 1'b1;
    #1;
    chk_zero_outputs("async_clr");
    smpl_vld0 = 1'b0;
    @(posedge CLK); #1;
    CLR = 1'b0;
    idle(1);
    exp0(16'd0, 8'h00, 8'h00, 24'h0, 1'b1, 1'b0);
    cyc0(1'b0, 8'h00, 1'b1);

    budget = 20;
    while ((q0.size() != 0 || q1.size() != 0) && budget > 0) begin
      idle(1);
      budget--;
    end
    idle(1);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
